// File: rtl/rob_dispatch_if.sv
// rob_dispatch_if: rename-to-ROB allocation, FU completion and retire/free buses.
interface rob_dispatch_if #(
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [6:0]        alloc_opcode;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_pd;
  logic [PREG_W-1:0] alloc_old_pd;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cmpl_valid;
  logic [TAG_W-1:0]  cmpl_tag;
  logic [31:0]       cmpl_result;
  logic              ret_valid;
  logic              ret_we;
  logic [AREG_W-1:0] ret_rd;
  logic [PREG_W-1:0] ret_pd;
  logic [31:0]       ret_data;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic [TAG_W:0]    count;
  modport master (
    output alloc_valid, alloc_opcode, alloc_rd, alloc_pd, alloc_old_pd,
           cmpl_valid, cmpl_tag, cmpl_result,
    input  alloc_ready, alloc_tag, ret_valid, ret_we, ret_rd, ret_pd, ret_data,
           free_valid, free_preg, count
  );
  modport slave (
    input  alloc_valid, alloc_opcode, alloc_rd, alloc_pd, alloc_old_pd,
           cmpl_valid, cmpl_tag, cmpl_result,
    output alloc_ready, alloc_tag, ret_valid, ret_we, ret_rd, ret_pd, ret_data,
           free_valid, free_preg, count
  );
endinterface

// File: rtl/rob_dispatch.sv
// rob_dispatch: reorder buffer assigning in-order tags, recording OoO completions, retiring in order.
module rob_dispatch #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  rob_dispatch_if.slave bus
);
  localparam logic [6:0] OP_SW = 7'b0100011;
  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W:0]    count;
  logic [DEPTH-1:0]  valid, complete, has_dest;
  logic [AREG_W-1:0] rd_q  [DEPTH];
  logic [PREG_W-1:0] pd_q  [DEPTH];
  logic [PREG_W-1:0] old_q [DEPTH];
  logic [31:0]       res_q [DEPTH];
  logic              do_alloc, do_ret, do_cmpl;
  assign bus.alloc_ready = count != (TAG_W+1)'(DEPTH);
  assign bus.alloc_tag   = tail;
  assign bus.count       = count;
  assign do_alloc = bus.alloc_valid && bus.alloc_ready;
  assign do_ret   = valid[head] && complete[head];
  assign do_cmpl  = bus.cmpl_valid && valid[bus.cmpl_tag];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      if (do_cmpl) complete[bus.cmpl_tag] <= 1'b1;
      if (do_ret) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (do_alloc) begin
        valid[tail]    <= 1'b1;
        complete[tail] <= 1'b0;
        tail           <= tail + 1'b1;
      end
      count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_ret);
    end
  // payload carries no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      has_dest[tail] <= bus.alloc_opcode != OP_SW;
      rd_q[tail]     <= bus.alloc_rd;
      pd_q[tail]     <= bus.alloc_pd;
      old_q[tail]    <= bus.alloc_old_pd;
    end
    if (do_cmpl) res_q[bus.cmpl_tag] <= bus.cmpl_result;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.ret_valid  <= 1'b0;
      bus.ret_we     <= 1'b0;
      bus.ret_rd     <= '0;
      bus.ret_pd     <= '0;
      bus.ret_data   <= '0;
      bus.free_valid <= 1'b0;
      bus.free_preg  <= '0;
    end else begin
      bus.ret_valid  <= do_ret;
      bus.free_valid <= do_ret && has_dest[head];
      if (do_ret) begin
        bus.ret_we    <= has_dest[head];
        bus.ret_rd    <= rd_q[head];
        bus.ret_pd    <= pd_q[head];
        bus.ret_data  <= res_q[head];
        bus.free_preg <= old_q[head];
      end
    end
endmodule

// File: tb/tb_rob_dispatch.sv
// tb_rob_dispatch: vector table for basic/OoO/SW retire, hand sequences for full, streaming and reset.
module tb_rob_dispatch;
  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] SW  = 7'b0100011;
  typedef struct {
    logic        av;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [5:0]  pd, opd;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cr;
    logic [3:0]  e_tag;
    logic        e_rdy;
    logic [4:0]  e_cnt;
    logic        e_rv, e_we;
    logic [4:0]  e_rrd;
    logic [5:0]  e_rpd;
    logic [31:0] e_rdat;
    logic        e_fv;
    logic [5:0]  e_fp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  string ctx = "reset";
  vec_t v [16];
  rob_dispatch_if #(.TAG_W(4), .PREG_W(6), .AREG_W(5)) bus ();
  rob_dispatch #(.DEPTH(16), .TAG_W(4), .PREG_W(6), .AREG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(int av, int op, int rd, int pd, int opd, int cv, int ct, int cr,
                              int tag, int rdy, int cnt, int rv, int we, int rrd, int rpd,
                              int rdat, int fv, int fp);
    vec_t r;
    r.av = 1'(av); r.op = 7'(op); r.rd = 5'(rd); r.pd = 6'(pd); r.opd = 6'(opd);
    r.cv = 1'(cv); r.ct = 4'(ct); r.cr = 32'(cr);
    r.e_tag = 4'(tag); r.e_rdy = 1'(rdy); r.e_cnt = 5'(cnt); r.e_rv = 1'(rv); r.e_we = 1'(we);
    r.e_rrd = 5'(rrd); r.e_rpd = 6'(rpd); r.e_rdat = 32'(rdat); r.e_fv = 1'(fv); r.e_fp = 6'(fp);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0h, expected %0h", ctx, nm, act, exp);
    end
  endtask
  task automatic drive(input logic av, input logic [6:0] op, input logic [4:0] rd,
                       input logic [5:0] pd, input logic [5:0] opd,
                       input logic cv, input logic [3:0] ct, input logic [31:0] cr);
    bus.alloc_valid = av; bus.alloc_opcode = op; bus.alloc_rd = rd;
    bus.alloc_pd = pd; bus.alloc_old_pd = opd;
    bus.cmpl_valid = cv; bus.cmpl_tag = ct; bus.cmpl_result = cr;
  endtask
  task automatic ret_chk(input logic [4:0] cnt, input logic rv, input logic [4:0] rd);
    chk("count", 32'(bus.count), 32'(cnt));
    chk("ret_valid", 32'(bus.ret_valid), 32'(rv));
    if (rv) chk("ret_rd", 32'(bus.ret_rd), 32'(rd));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = mk(1, ADD, 3, 10, 3, 0, 0, 0,      0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v[1]  = mk(0, 0, 0, 0, 0,    1, 0, 'h55,   1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v[2]  = mk(0, 0, 0, 0, 0,    0, 0, 0,      1, 1, 0, 1, 1, 3, 10, 'h55, 1, 3);
    v[3]  = mk(1, ADD, 1, 11, 1, 0, 0, 0,      1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v[4]  = mk(1, ADD, 2, 12, 2, 0, 0, 0,      2, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    v[5]  = mk(1, ADD, 4, 13, 4, 0, 0, 0,      3, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    v[6]  = mk(0, 0, 0, 0, 0,    1, 3, 'h33,   4, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    v[7]  = mk(0, 0, 0, 0, 0,    1, 2, 'h22,   4, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    v[8]  = mk(0, 0, 0, 0, 0,    1, 1, 'h11,   4, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    v[9]  = mk(0, 0, 0, 0, 0,    0, 0, 0,      4, 1, 2, 1, 1, 1, 11, 'h11, 1, 1);
    v[10] = mk(0, 0, 0, 0, 0,    0, 0, 0,      4, 1, 1, 1, 1, 2, 12, 'h22, 1, 2);
    v[11] = mk(0, 0, 0, 0, 0,    0, 0, 0,      4, 1, 0, 1, 1, 4, 13, 'h33, 1, 4);
    v[12] = mk(0, 0, 0, 0, 0,    0, 0, 0,      4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    v[13] = mk(1, SW, 5, 14, 5,  0, 0, 0,      4, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v[14] = mk(0, 0, 0, 0, 0,    1, 4, 'h77,   5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v[15] = mk(0, 0, 0, 0, 0,    0, 0, 0,      5, 1, 0, 1, 0, 5, 14, 'h77, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("count", 32'(bus.count), 0);
    chk("ret_valid", 32'(bus.ret_valid), 0);
    chk("free_valid", 32'(bus.free_valid), 0);
    chk("ret_data", bus.ret_data, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ctx = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(v[i].av, v[i].op, v[i].rd, v[i].pd, v[i].opd, v[i].cv, v[i].ct, v[i].cr);
      #1;
      chk("alloc_tag", 32'(bus.alloc_tag), 32'(v[i].e_tag));
      chk("alloc_ready", 32'(bus.alloc_ready), 32'(v[i].e_rdy));
      @(posedge clk);
      #1;
      chk("count", 32'(bus.count), 32'(v[i].e_cnt));
      chk("ret_valid", 32'(bus.ret_valid), 32'(v[i].e_rv));
      chk("free_valid", 32'(bus.free_valid), 32'(v[i].e_fv));
      if (v[i].e_rv) begin
        chk("ret_we", 32'(bus.ret_we), 32'(v[i].e_we));
        chk("ret_rd", 32'(bus.ret_rd), 32'(v[i].e_rrd));
        chk("ret_pd", 32'(bus.ret_pd), 32'(v[i].e_rpd));
        chk("ret_data", bus.ret_data, v[i].e_rdat);
      end
      if (v[i].e_fv) chk("free_preg", 32'(bus.free_preg), 32'(v[i].e_fp));
    end
    ctx = "fill";
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, ADD, 5'(i), 6'(16 + i), 6'(i), 0, 0, 0);
      #1 chk("fill_tag", 32'(bus.alloc_tag), 32'(i));
    end
    @(negedge clk);
    drive(1, ADD, 31, 63, 63, 0, 0, 0);
    #1;
    chk("full_count", 32'(bus.count), 16);
    chk("full_ready", 32'(bus.alloc_ready), 0);
    @(negedge clk);
    chk("ignored_count", 32'(bus.count), 16);
    drive(0, 0, 0, 0, 0, 1, 0, 'hA0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    ret_chk(15, 1, 0);
    chk("ret_pd_not_overwritten", 32'(bus.ret_pd), 16);
    chk("ret_data", bus.ret_data, 'hA0);
    chk("ready_after_ret", 32'(bus.alloc_ready), 1);
    chk("wrap_tag", 32'(bus.alloc_tag), 0);
    ctx = "stream";
    @(negedge clk);
    drive(1, ADD, 20, 40, 20, 1, 1, 'hB1);
    @(posedge clk);
    #1 ret_chk(16, 0, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      drive(1, ADD, 20, 40, 20, 1, 4'(j + 2), 32'(j));
      #1;
      chk("stream_ready", 32'(bus.alloc_ready), (j == 0) ? 0 : 1);
      chk("stream_tag", 32'(bus.alloc_tag), (j == 0) ? 1 : j);
      @(posedge clk);
      #1 ret_chk(15, 1, 5'(j + 1));
    end
    ctx = "async_reset";
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 ret_chk(14, 1, 6);
    #1 rst_n = 1'b0;
    #1;
    chk("count", 32'(bus.count), 0);
    chk("ret_valid", 32'(bus.ret_valid), 0);
    chk("free_valid", 32'(bus.free_valid), 0);
    chk("ret_rd", 32'(bus.ret_rd), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    drive(1, ADD, 7, 9, 7, 0, 0, 0);
    #1 chk("post_reset_tag", 32'(bus.alloc_tag), 0);
    @(posedge clk);
    #1 chk("post_reset_count", 32'(bus.count), 1);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
